fmlbrg_burst: RTL and testbench

FML 8x16 burst engine for the FML bridge cache. It moves whole cache lines between the FML memory controller and the bridge's byte-lane data memory. A line fill streams an 8-word FML read burst into the data memory's write port. A writeback reads a line through the data memory's secondary read-only port and drives it out as an 8-word FML write burst. The block sits between the bridge's tag/control logic, which issues requests, and the FML controller port.

---
 rtl/fmlbrg_burst_pkg.sv | 17 +
 rtl/fmlbrg_burst.sv | 137 +++++++++++++
 tb/tb_fmlbrg_burst.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmlbrg_burst_pkg.sv
// Shared constants and FSM encoding for the FML bridge burst engine.
package fmlbrg_burst_pkg;

  localparam int unsigned BURST_LEN = 8;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned LINE_OFS  = 3;
  localparam int unsigned FML_OFS   = 4;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_BURST,
    FILL_REQ,
    FILL_BURST
  } state_t;

endpackage

// File: rtl/fmlbrg_burst.sv
// FML 8x16 burst engine: moves whole cache lines between the FML controller
// and the bridge data memory (fill = FML read burst, writeback = FML write burst).
module fmlbrg_burst
  import fmlbrg_burst_pkg::*;
#(
  parameter int fml_depth = 26,
  parameter int depth     = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,

  input  logic                    req_fill,
  input  logic                    req_evict,
  input  logic [depth-4:0]        req_line,
  input  logic [fml_depth-5:0]    fill_adr,
  input  logic [fml_depth-5:0]    evict_adr,
  output logic                    busy,
  output logic                    done,

  output logic [depth-1:0]        dm_a,
  output logic [1:0]              dm_we,
  output logic [WORD_W-1:0]       dm_di,
  output logic [depth-1:0]        dm_a2,
  input  logic [WORD_W-1:0]       dm_do2,

  output logic [fml_depth-1:0]    fml_adr,
  output logic                    fml_stb,
  output logic                    fml_we,
  output logic [1:0]              fml_sel,
  input  logic                    fml_ack,
  output logic [WORD_W-1:0]       fml_do,
  input  logic [WORD_W-1:0]       fml_di
);

  localparam logic [LINE_OFS-1:0] LAST_WORD = LINE_OFS'(BURST_LEN - 1);

  state_t                 state, state_next;
  logic [LINE_OFS-1:0]    cnt, cnt_next, cnt_inc;
  logic                   done_next;
  logic [depth-4:0]       line;
  logic [fml_depth-5:0]   fill_a, evict_a;
  logic                   fill_pend;
  logic                   accept;

  assign accept  = (state == IDLE) && (req_evict || req_fill);
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      done      <= 1'b0;
      line      <= '0;
      fill_a    <= '0;
      evict_a   <= '0;
      fill_pend <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= done_next;
      if (accept) begin
        line      <= req_line;
        fill_a    <= fill_adr;
        evict_a   <= evict_adr;
        fill_pend <= req_fill;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    fml_stb    = 1'b0;
    fml_we     = 1'b0;
    fml_adr    = '0;
    dm_a       = '0;
    dm_we      = '0;
    dm_a2      = '0;
    unique case (state)
      IDLE: begin
        if (req_evict)     state_next = WB_REQ;
        else if (req_fill) state_next = FILL_REQ;
      end
      WB_REQ: begin
        fml_stb = 1'b1;
        fml_we  = 1'b1;
        fml_adr = {evict_a, {FML_OFS{1'b0}}};
        dm_a2   = {line, {LINE_OFS{1'b0}}};
        if (fml_ack) begin
          state_next = WB_BURST;
          cnt_next   = '0;
        end
      end
      WB_BURST: begin
        // Read address runs one word ahead to cover the data memory read latency.
        fml_we   = 1'b1;
        fml_adr  = {evict_a, {FML_OFS{1'b0}}};
        dm_a2    = {line, cnt_inc};
        cnt_next = cnt_inc;
        if (cnt == LAST_WORD) begin
          if (fill_pend) begin
            state_next = FILL_REQ;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      FILL_REQ: begin
        fml_stb = 1'b1;
        fml_adr = {fill_a, {FML_OFS{1'b0}}};
        if (fml_ack) begin
          state_next = FILL_BURST;
          cnt_next   = '0;
        end
      end
      FILL_BURST: begin
        fml_adr  = {fill_a, {FML_OFS{1'b0}}};
        dm_a     = {line, cnt};
        dm_we    = 2'b11;
        cnt_next = cnt_inc;
        if (cnt == LAST_WORD) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign fml_sel = 2'b11;
  assign fml_do  = dm_do2;
  assign dm_di   = fml_di;

endmodule

// File: tb/tb_fmlbrg_burst.sv
// Bench for fmlbrg_burst: transaction-level schedule model, data memory model and FML master-side stimulus.
module tb_fmlbrg_burst;

  logic        sys_clk, sys_rst;
  logic        req_fill, req_evict;
  logic [4:0]  req_line;
  logic [21:0] fill_adr, evict_adr;
  logic        busy, done;
  logic [7:0]  dm_a, dm_a2;
  logic [1:0]  dm_we;
  logic [15:0] dm_di, dm_do2;
  logic [25:0] fml_adr;
  logic        fml_stb, fml_we, fml_ack;
  logic [1:0]  fml_sel;
  logic [15:0] fml_do, fml_di;

  fmlbrg_burst #(.fml_depth(26), .depth(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_fill(req_fill), .req_evict(req_evict), .req_line(req_line),
    .fill_adr(fill_adr), .evict_adr(evict_adr), .busy(busy), .done(done),
    .dm_a(dm_a), .dm_we(dm_we), .dm_di(dm_di), .dm_a2(dm_a2), .dm_do2(dm_do2),
    .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we), .fml_sel(fml_sel),
    .fml_ack(fml_ack), .fml_do(fml_do), .fml_di(fml_di)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Data memory: byte-lane write port, registered-address secondary read port, preload backdoor.
  logic [15:0] mem [256];
  logic        pl_we;
  logic [7:0]  pl_a;
  logic [15:0] pl_d;
  always @(posedge sys_clk) begin
    if (pl_we) mem[pl_a] <= pl_d;
    else begin
      if (dm_we[0]) mem[dm_a][7:0]  <= dm_di[7:0];
      if (dm_we[1]) mem[dm_a][15:8] <= dm_di[15:8];
    end
    dm_do2 <= mem[dm_a2];
  end

  typedef struct {
    logic        busy, done, stb;
    logic        chk_adr, we;
    logic [25:0] adr;
    logic [1:0]  dmwe;
    logic        chk_dma;
    logic [7:0]  dma;
    logic        chk_dma2;
    logic [7:0]  dma2;
    logic        chk_do;
    logic [15:0] dov;
    int          widx;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_mem [256];
  logic [15:0] fill_pat [8];
  logic [15:0] wcap [8];
  logic [25:0] last_adr;
  logic        last_we;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, want, $time);
    end
  endtask

  function automatic exp_t idle_e(input logic d);
    exp_t e;
    e = '{default: '0};
    e.done = d;
    return e;
  endfunction

  // One compare process: each queued record describes what the outputs must be in that cycle.
  always @(negedge sys_clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("fml_stb", 32'(fml_stb), 32'(e.stb));
      chk("fml_sel", 32'(fml_sel), 32'h3);
      chk("dm_we", 32'(dm_we), 32'(e.dmwe));
      if (e.chk_adr) begin
        chk("fml_adr", 32'(fml_adr), 32'(e.adr));
        chk("fml_we", 32'(fml_we), 32'(e.we));
        last_adr = fml_adr;
        last_we  = fml_we;
      end
      if (e.chk_dma)  chk("dm_a", 32'(dm_a), 32'(e.dma));
      if (e.chk_dma2) chk("dm_a2", 32'(dm_a2), 32'(e.dma2));
      if (e.chk_do) begin
        chk("fml_do", 32'(fml_do), 32'(e.dov));
        wcap[e.widx] = fml_do;
      end
    end
  end

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    ref_mem[a] = d;
    @(posedge sys_clk);
    #1;
    pl_we = 1'b0;
  endtask

  // Builds the cycle schedule of one request from the timing rules and drives the FML side.
  task automatic txn(input bit ev, input bit fl, input logic [4:0] ln, input logic [21:0] fa,
                     input logic [21:0] ea, input int dwb, input int dfl, input bit poke);
    exp_t e;
    req_evict = ev; req_fill = fl; req_line = ln; fill_adr = fa; evict_adr = ea;
    step(idle_e(1'b0));
    req_evict = 1'b0; req_fill = 1'b0;
    req_line = 5'($urandom); fill_adr = 22'($urandom); evict_adr = 22'($urandom);
    if (ev) begin
      for (int i = 0; i <= dwb; i++) begin
        fml_ack = (i == dwb);
        e = idle_e(1'b0);
        e.busy = 1'b1; e.stb = 1'b1; e.chk_adr = 1'b1; e.we = 1'b1; e.adr = {ea, 4'h0};
        e.chk_dma2 = 1'b1; e.dma2 = {ln, 3'd0};
        step(e);
      end
      fml_ack = 1'b0;
      for (int k = 0; k < 8; k++) begin
        e = idle_e(1'b0);
        e.busy = 1'b1;
        e.chk_dma2 = 1'b1; e.dma2 = {ln, 3'(k + 1)};
        e.chk_do = 1'b1; e.dov = ref_mem[{ln, 3'(k)}]; e.widx = k;
        step(e);
      end
    end
    if (fl) begin
      for (int i = 0; i <= dfl; i++) begin
        fml_ack = (i == dfl);
        e = idle_e(1'b0);
        e.busy = 1'b1; e.stb = 1'b1; e.chk_adr = 1'b1; e.we = 1'b0; e.adr = {fa, 4'h0};
        step(e);
      end
      fml_ack = 1'b0;
      for (int k = 0; k < 8; k++) begin
        fml_di = fill_pat[k];
        if (poke && k == 3) req_fill = 1'b1;
        e = idle_e(1'b0);
        e.busy = 1'b1; e.dmwe = 2'b11; e.chk_dma = 1'b1; e.dma = {ln, 3'(k)};
        step(e);
        req_fill = 1'b0;
        ref_mem[{ln, 3'(k)}] = fill_pat[k];
      end
      fml_di = 16'($urandom);
    end
    step(idle_e(1'b1));
    step(idle_e(1'b0));
    step(idle_e(1'b0));
  endtask

  initial begin
    exp_t e;
    bit ev, fl;
    sys_rst = 1'b1;
    req_fill = 1'b0; req_evict = 1'b0; req_line = '0; fill_adr = '0; evict_adr = '0;
    fml_ack = 1'b0; fml_di = '0; pl_we = 1'b0; pl_a = '0; pl_d = '0;
    last_adr = '0; last_we = 1'b0;
    #13;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_stb", 32'(fml_stb), 0);
    chk("rst_we", 32'(fml_we), 0);
    chk("rst_adr", 32'(fml_adr), 0);
    chk("rst_dm_we", 32'(dm_we), 0);
    chk("rst_dm_a", 32'(dm_a), 0);
    chk("rst_dm_a2", 32'(dm_a2), 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < 256; i++) preload(8'(i), 16'($urandom));

    // Fill only
    for (int k = 0; k < 8; k++) fill_pat[k] = 16'(16'hA000 + k);
    txn(1'b0, 1'b1, 5'd3, 22'h12345, 22'h0, 0, 2, 1'b0);
    chk("fill_lit_adr", 32'(last_adr), 32'h0123450);
    chk("fill_lit_we", 32'(last_we), 0);
    for (int k = 0; k < 8; k++) chk("fill_lit_mem", 32'(mem[8'(24 + k)]), 32'(16'hA000 + k));

    // Evict only
    for (int k = 0; k < 8; k++) preload(8'(40 + k), 16'(16'hB000 + k));
    txn(1'b1, 1'b0, 5'd5, 22'h0, 22'h00100, 1, 0, 1'b0);
    chk("evict_lit_adr", 32'(last_adr), 32'h0001000);
    chk("evict_lit_we", 32'(last_we), 1);
    for (int k = 0; k < 8; k++) chk("evict_lit_data", 32'(wcap[k]), 32'(16'hB000 + k));

    // Evict + fill on the same line
    for (int k = 0; k < 8; k++) fill_pat[k] = 16'($urandom);
    txn(1'b1, 1'b1, 5'd7, 22'h2AAAA, 22'h15555, 0, 0, 1'b0);

    // Ack delayed 20 cycles, plus a request while busy
    for (int k = 0; k < 8; k++) fill_pat[k] = 16'($urandom);
    txn(1'b1, 1'b1, 5'd9, 22'h3F00F, 22'h0ABCD, 20, 20, 1'b1);

    // Randomized requests
    for (int n = 0; n < 12; n++) begin
      ev = 1'($urandom);
      fl = ev ? 1'($urandom) : 1'b1;
      for (int k = 0; k < 8; k++) fill_pat[k] = 16'($urandom);
      txn(ev, fl, 5'($urandom), 22'($urandom), 22'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    // Reset at word 4 of a fill
    for (int k = 0; k < 8; k++) fill_pat[k] = 16'($urandom);
    req_fill = 1'b1; req_line = 5'd2; fill_adr = 22'h01234;
    step(idle_e(1'b0));
    req_fill = 1'b0;
    fml_ack = 1'b1;
    e = idle_e(1'b0);
    e.busy = 1'b1; e.stb = 1'b1; e.chk_adr = 1'b1; e.we = 1'b0; e.adr = 26'h0012340;
    step(e);
    fml_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fml_di = fill_pat[k];
      e = idle_e(1'b0);
      e.busy = 1'b1; e.dmwe = 2'b11; e.chk_dma = 1'b1; e.dma = {5'd2, 3'(k)};
      step(e);
      ref_mem[{5'd2, 3'(k)}] = fill_pat[k];
    end
    fml_di = fill_pat[4];
    #1 sys_rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_stb", 32'(fml_stb), 0);
    chk("arst_we", 32'(fml_we), 0);
    chk("arst_adr", 32'(fml_adr), 0);
    chk("arst_dm_we", 32'(dm_we), 0);
    chk("arst_dm_a", 32'(dm_a), 0);
    chk("arst_dm_a2", 32'(dm_a2), 0);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    step(idle_e(1'b0));
    for (int k = 0; k < 8; k++) fill_pat[k] = 16'($urandom);
    txn(1'b0, 1'b1, 5'd2, 22'h05678, 22'h0, 1, 1, 1'b0);
    chk("post_rst_adr", 32'(last_adr), 32'h0056780);

    @(negedge sys_clk);
    for (int i = 0; i < 256; i++) chk("mem_final", 32'(mem[i]), 32'(ref_mem[i]));
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
